// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch program counter.
//   pc_sel_e   - next-PC source chosen each cycle
//   INSN_BYTES - sequential instruction stride in bytes
//   ras_ptr_w  - RAS top-pointer width for a given RAS depth
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_RET,
    SEL_REDIR,
    SEL_TRAP,
    SEL_HOLD
  } pc_sel_e;

  localparam int unsigned INSN_BYTES = 4;

  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between control/branch-resolution
// logic (master) and the fetch program counter (slave).
//   requests : stall, trap_valid, trap_vector, redirect_valid, redirect_addr,
//              call_valid, ret_valid
//   responses: pc, pc_plus4, ras_empty, ras_miss, misalign, misalign_addr
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            call_valid;
  logic            ret_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            ras_empty;
  logic            ras_miss;
  logic            misalign;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    output stall, trap_valid, trap_vector, redirect_valid, redirect_addr,
           call_valid, ret_valid,
    input  pc, pc_plus4, ras_empty, ras_miss, misalign, misalign_addr
  );

  modport slave (
    input  stall, trap_valid, trap_vector, redirect_valid, redirect_addr,
           call_valid, ret_valid,
    output pc, pc_plus4, ras_empty, ras_miss, misalign, misalign_addr
  );

endinterface

// File: rtl/pc_unit_return_addr_stack.sv
// return_addr_stack: circular return-address stack with top pointer and count.
//   clk, rst    - clock, async active-high reset (clears pointer and count)
//   i_push      - push i_push_data
//   i_pop       - pop top entry (ignored when empty)
//   i_push_data - address to push
//   o_top       - current top entry
//   o_empty     - no entries held
//   o_full      - RAS_DEPTH entries held
// Push when full overwrites the oldest entry; push+pop replaces the top.
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_push_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full
);

  localparam int unsigned PW = ras_ptr_w(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic            w_pop_eff;
  logic [PW-1:0]   w_wr_idx;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(RAS_DEPTH));
  assign o_top     = r_mem[r_top];
  assign w_pop_eff = i_pop && !o_empty;
  // Simultaneous push+pop rewrites the top slot in place.
  assign w_wr_idx  = w_pop_eff ? r_top : r_top + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push && w_pop_eff) begin
      r_top   <= r_top;
      r_count <= r_count;
    end else if (i_push) begin
      // Pointer wrap naturally drops the oldest entry when full.
      r_top <= r_top + PW'(1);
      if (!o_full) r_count <= r_count + CW'(1);
    end else if (w_pop_eff) begin
      r_top   <= r_top - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with trap/redirect/call/return selection,
// stall support and a return-address stack.
//   clk, rst - clock, async active-high reset
//   bus      - pc_unit_if.slave: requests in, pc/pc_plus4/RAS status out
// Next-PC priority: trap > redirect/call > ret > sequential; stall holds
// everything except a trap.
// Optional macro PC_MISALIGN_CHECK_EN: reject redirect/call targets with
// addr[1:0] != 0 (pc holds, misalign pulses). Undefined: low bits forced to 0.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);

  logic [XLEN-1:0] r_pc;
  logic            r_ras_miss;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_ras_top;
  logic [XLEN-1:0] w_pc_next;
  logic            w_ras_empty;
  logic            w_unused_ras_full;
  logic            w_redir_req;
  logic            w_tgt_bad;
  logic            w_push;
  logic            w_pop;
  pc_sel_e         w_sel;

  assign w_pc_plus4  = r_pc + XLEN'(INSN_BYTES);
  assign w_tgt       = bus.redirect_addr & ~XLEN'(INSN_BYTES - 1);
  assign w_redir_req = bus.redirect_valid || bus.call_valid;

`ifdef PC_MISALIGN_CHECK_EN
  assign w_tgt_bad = |bus.redirect_addr[1:0];
`else
  assign w_tgt_bad = 1'b0;
`endif

  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.trap_valid)      w_sel = SEL_TRAP;
    else if (bus.stall)      w_sel = SEL_HOLD;
    else if (w_redir_req)    w_sel = w_tgt_bad ? SEL_HOLD : SEL_REDIR;
    else if (bus.ret_valid)  w_sel = SEL_RET;
  end

  // call+ret together pops then pushes, leaving the count unchanged.
  assign w_push = (w_sel == SEL_REDIR) && bus.call_valid;
  assign w_pop  = ((w_sel == SEL_REDIR) && bus.call_valid && bus.ret_valid) ||
                  (w_sel == SEL_RET);

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_sel)
      SEL_TRAP:  w_pc_next = bus.trap_vector;
      SEL_HOLD:  w_pc_next = r_pc;
      SEL_REDIR: w_pc_next = w_tgt;
      SEL_RET:   w_pc_next = w_ras_empty ? w_tgt : w_ras_top;
      default:   w_pc_next = w_pc_plus4;
    endcase
  end

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_plus4),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_unused_ras_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_ras_miss <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_ras_miss <= (w_sel == SEL_RET) && w_ras_empty;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign <= !bus.trap_valid && !bus.stall && w_redir_req && w_tgt_bad;
      if (!bus.trap_valid && !bus.stall && w_redir_req && w_tgt_bad)
        r_misalign_addr <= bus.redirect_addr;
    end
  end

  assign bus.misalign      = r_misalign;
  assign bus.misalign_addr = r_misalign_addr;
`else
  assign bus.misalign      = 1'b0;
  assign bus.misalign_addr = '0;
`endif

  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_miss  = r_ras_miss;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [31:0] RV        = 32'h0000_0000;
`ifdef PC_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_unit_if #(.XLEN(XLEN)) bus ();

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .RAS_DEPTH    (RAS_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pc value plus a queue of link addresses (back = top).
  logic [31:0] m_pc;
  logic [31:0] m_mis_addr;
  bit          m_miss;
  bit          m_mis;
  logic [31:0] m_ras[$];

  task automatic idle();
    bus.stall          = 1'b0;
    bus.trap_valid     = 1'b0;
    bus.trap_vector    = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.call_valid     = 1'b0;
    bus.ret_valid      = 1'b0;
  endtask

  task automatic model_reset();
    m_pc       = RV;
    m_mis_addr = '0;
    m_miss     = 1'b0;
    m_mis      = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    m_miss = 1'b0;
    m_mis  = 1'b0;
    if (bus.trap_valid) begin
      m_pc = bus.trap_vector;
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (bus.redirect_valid || bus.call_valid) begin
      if (CHK && bus.redirect_addr[1:0] != 2'b00) begin
        m_mis      = 1'b1;
        m_mis_addr = bus.redirect_addr;
      end else begin
        if (bus.call_valid && bus.ret_valid && m_ras.size() > 0)
          void'(m_ras.pop_back());
        if (bus.call_valid) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        m_pc = bus.redirect_addr & ~32'h3;
      end
    end else if (bus.ret_valid) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc   = bus.redirect_addr & ~32'h3;
        m_miss = 1'b1;
      end
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    model_reset();
    #2;
    checks++; if (bus.pc !== RV) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, RV); end
    checks++; if (bus.pc_plus4 !== RV + 32'd4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected %h", bus.pc_plus4, RV + 32'd4); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL reset_ras_empty: got %b expected 1", bus.ras_empty); end
    checks++; if (bus.ras_miss !== 1'b0) begin errors++; $display("FAIL reset_ras_miss: got %b expected 0", bus.ras_miss); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", bus.misalign); end
    checks++; if (bus.misalign_addr !== 32'h0) begin errors++; $display("FAIL reset_misalign_addr: got %h expected 0", bus.misalign_addr); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, bus.pc, 32'(4 * i)); end
      checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL seq_ras_empty[%0d]: got %b expected 1", i, bus.ras_empty); end
    end
  endtask

  task automatic test_call_ret();
    tick();
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL callret_start: got %h expected 00000010", bus.pc); end
    bus.call_valid    = 1'b1;
    bus.redirect_addr = 32'h100;
    tick();
    idle();
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL call_target: got %h expected 00000100", bus.pc); end
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL call_ras_empty: got %b expected 0", bus.ras_empty); end
    tick();
    tick();
    checks++; if (bus.pc !== 32'h108) begin errors++; $display("FAIL callret_mid: got %h expected 00000108", bus.pc); end
    bus.ret_valid     = 1'b1;
    bus.redirect_addr = $urandom & 32'hFFFF_FFFC;
    tick();
    idle();
    checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL ret_target: got %h expected 00000014", bus.pc); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL ret_ras_empty: got %b expected 1", bus.ras_empty); end
    checks++; if (bus.ras_miss !== 1'b0) begin errors++; $display("FAIL ret_ras_miss: got %b expected 0", bus.ras_miss); end
  endtask

  task automatic test_nested_calls();
    logic [31:0] links [5];
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    for (int k = 0; k < 5; k++) begin
      tgt               = 32'h1000 + 32'(k * 32'h100) + 32'($urandom_range(0, 15) << 2);
      links[k]          = m_pc + 32'd4;
      bus.call_valid    = 1'b1;
      bus.redirect_addr = tgt;
      tick();
      idle();
      checks++; if (bus.pc !== tgt) begin errors++; $display("FAIL nest_call[%0d]: got %h expected %h", k, bus.pc, tgt); end
    end
    for (int k = 0; k < 5; k++) begin
      bus.ret_valid     = 1'b1;
      bus.redirect_addr = 32'h3000;
      tick();
      idle();
      exp_pc = (k < 4) ? links[4 - k] : 32'h3000;
      checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL nest_ret[%0d]: got %h expected %h", k, bus.pc, exp_pc); end
      checks++; if (bus.ras_miss !== (k == 4)) begin errors++; $display("FAIL nest_ras_miss[%0d]: got %b expected %b", k, bus.ras_miss, (k == 4)); end
    end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL nest_ras_empty: got %b expected 1", bus.ras_empty); end
    tick();
    checks++; if (bus.ras_miss !== 1'b0) begin errors++; $display("FAIL nest_miss_pulse: got %b expected 0", bus.ras_miss); end
  endtask

  task automatic test_stall_trap();
    logic [31:0] p0;
    p0                 = m_pc;
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h200;
    tick();
    checks++; if (bus.pc !== p0) begin errors++; $display("FAIL stall_hold: got %h expected %h", bus.pc, p0); end
    bus.trap_valid  = 1'b1;
    bus.trap_vector = 32'h80;
    tick();
    idle();
    checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL stall_trap: got %h expected 00000080", bus.pc); end
    tick();
    checks++; if (bus.pc !== 32'h84) begin errors++; $display("FAIL trap_then_seq: got %h expected 00000084", bus.pc); end
  endtask

  task automatic test_misalign();
    logic [31:0] p0;
    p0                 = m_pc;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h102;
    tick();
    idle();
`ifdef PC_MISALIGN_CHECK_EN
    checks++; if (bus.pc !== p0) begin errors++; $display("FAIL misalign_hold: got %h expected %h", bus.pc, p0); end
    checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b expected 1", bus.misalign); end
    checks++; if (bus.misalign_addr !== 32'h102) begin errors++; $display("FAIL misalign_addr: got %h expected 00000102", bus.misalign_addr); end
    tick();
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b expected 0", bus.misalign); end
    checks++; if (bus.pc !== p0 + 32'd4) begin errors++; $display("FAIL misalign_resume: got %h expected %h", bus.pc, p0 + 32'd4); end
`else
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL misalign_forced: got %h expected 00000100 (from %h)", bus.pc, p0); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_flag: got %b expected 0", bus.misalign); end
    checks++; if (bus.misalign_addr !== 32'h0) begin errors++; $display("FAIL misalign_addr: got %h expected 0", bus.misalign_addr); end
`endif
  endtask

  task automatic test_wrap();
    bus.trap_valid  = 1'b1;
    bus.trap_vector = 32'hFFFF_FFFC;
    tick();
    idle();
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_trap: got %h expected fffffffc", bus.pc); end
    checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected 00000000", bus.pc_plus4); end
    tick();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h expected 00000000", bus.pc); end
  endtask

  task automatic test_reset_mid();
    bus.call_valid    = 1'b1;
    bus.redirect_addr = 32'h400;
    tick();
    bus.redirect_addr = 32'h500;
    tick();
    idle();
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL rstmid_pre_empty: got %b expected 0", bus.ras_empty); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.pc !== RV) begin errors++; $display("FAIL rstmid_pc: got %h expected %h", bus.pc, RV); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL rstmid_ras_empty: got %b expected 1", bus.ras_empty); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.pc !== RV + 32'd4) begin errors++; $display("FAIL rstmid_release: got %h expected %h", bus.pc, RV + 32'd4); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.trap_valid     = ($urandom_range(0, 15) == 0);
      bus.trap_vector    = $urandom & 32'hFFFF_FFFC;
      bus.stall          = ($urandom_range(0, 7) == 0);
      bus.redirect_valid = ($urandom_range(0, 5) == 0);
      bus.call_valid     = ($urandom_range(0, 5) == 0);
      bus.ret_valid      = ($urandom_range(0, 4) == 0);
      bus.redirect_addr  = $urandom;
      if ($urandom_range(0, 7) != 0) bus.redirect_addr[1:0] = 2'b00;
      tick();
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, bus.pc, m_pc); end
      checks++; if (bus.pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h expected %h", n, bus.pc_plus4, m_pc + 32'd4); end
      checks++; if (bus.ras_empty !== (m_ras.size() == 0)) begin errors++; $display("FAIL rnd_ras_empty[%0d]: got %b expected %b", n, bus.ras_empty, (m_ras.size() == 0)); end
      checks++; if (bus.ras_miss !== m_miss) begin errors++; $display("FAIL rnd_ras_miss[%0d]: got %b expected %b", n, bus.ras_miss, m_miss); end
      checks++; if (bus.misalign !== m_mis) begin errors++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", n, bus.misalign, m_mis); end
      checks++; if (bus.misalign_addr !== m_mis_addr) begin errors++; $display("FAIL rnd_misalign_addr[%0d]: got %h expected %h", n, bus.misalign_addr, m_mis_addr); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_nested_calls();
    test_stall_trap();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
